serial_alu_seq: RTL and testbench
=================================

Name: serial_alu_seq

Overview:
Multi-cycle, bit-serial WIDTH-bit ALU execution stage. It accepts a pair of operands and an ALU opcode on a start handshake and evaluates them LSB-first, one bit per clock, through a registered carry chain. It then presents a registered WIDTH-bit result with carry, zero and overflow flags, plus a one-cycle done pulse. It sits between operand/decode logic upstream and writeback downstream, and uses the same 3-bit opcode encoding as the per-bit ALU slice.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only when not busy
signal  input  3  opcode: 0=AND, 1=OR, 2=ADD, 6=SUB, 7=SLT
dataA  input  WIDTH  operand A, captured at accepted start
dataB  input  WIDTH  operand B, captured at accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
dataOut  output  WIDTH  registered result; holds until next accepted start completes
cOut  output  1  final carry out (ADD/SUB/SLT), else 0
zero  output  1  dataOut == 0
overflow  output  1  signed overflow of ADD/SUB/SLT subtraction, else 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, dataOut=0, cOut=0, zero=1, overflow=0.
  - Internal operand, shift and count registers are cleared.
  - Applies mid-operation: any in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (start accepted):
  - Latch dataA, dataB and signal.
  - bitCnt=0.
  - Carry register = 1 for SUB/SLT, 0 otherwise.
  - Go to RUN.
- start while busy is ignored; captured operands are not disturbed.
- RUN, each edge, for bit i = bitCnt:
  - bB = B[i] inverted for SUB/SLT.
  - Result bit: AND -> A[i]&B[i]; OR -> A[i]|B[i]; ADD/SUB/SLT -> A[i]^bB^carry.
  - Carry updates to the full-adder carry for ADD/SUB/SLT and is held at 0 for AND/OR.
  - The result bit shifts in from the MSB side, so bit 0 ends at position 0.
  - At i = WIDTH-1, the carry-in to the MSB is also recorded for overflow.
  - When bitCnt == WIDTH-1, go to DONE; otherwise bitCnt++.
- Entering DONE (same edge as the last RUN bit), register the outputs:
  - dataOut = result for AND/OR/ADD/SUB. For SLT, dataOut = {WIDTH-1 zeros, diffMSB ^ ovf}, i.e. the signed compare.
  - cOut = final carry (ADD/SUB/SLT), 0 otherwise.
  - overflow = carryIntoMSB ^ final carry (ADD/SUB/SLT), 0 otherwise.
  - zero is computed from the registered dataOut.
- DONE: done=1 for exactly one cycle, then IDLE unless start is accepted in that cycle.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH. Back-to-back throughput is one op per WIDTH+1 cycles.
- busy=1 exactly in RUN; busy and done are never both high.
- Illegal opcodes (3, 4, 5) execute as ADD, with carry-in 0.
- Outputs are stable between done pulses; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, dataOut=0, zero=1. Then reset mid-RUN at bit 10 -> IDLE, no done pulse, outputs cleared.
- ADD, WIDTH=32, A=0xFFFFFFFF, B=0x00000001, start at edge k -> done high only in the cycle after edge k+32: dataOut=0, cOut=1, zero=1, overflow=0. Also A=0x7FFFFFFF, B=1 -> dataOut=0x80000000, overflow=1, cOut=0.
- SUB, A=5, B=7 -> dataOut=0xFFFFFFFE, cOut=0, overflow=0, zero=0. Also A=7, B=7 -> dataOut=0, cOut=1, zero=1.
- SLT:
  - A=0x80000000, B=1 -> dataOut=1, overflow=1 (overflow-corrected compare).
  - A=5, B=3 -> dataOut=0.
  - A=0xFFFFFFFF, B=0 -> dataOut=1.
- AND/OR with A=0xF0F000FF, B=0x0FF00F0F:
  - AND -> 0x00F0000F, cOut=0, overflow=0.
  - OR -> 0xFFF00FFF.
  - Illegal opcode 4 with A=2, B=3 -> 5.
- Handshake:
  - Pulse start again at RUN bit 5 with different operands -> ignored; the first result is delivered.
  - Assert start during the done cycle -> new op accepted, busy next cycle, second done 33 cycles later.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU execution stage.
// Accepts operands and an opcode on start. Evaluates them LSB-first, one bit per
// clock, through a registered carry chain. Presents a registered result and flags
// with a one-cycle done pulse.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   start           - request, sampled only when not busy
//   signal[2:0]     - opcode: 0=AND 1=OR 2=ADD 6=SUB 7=SLT (3..5 act as ADD)
//   dataA, dataB    - operands, captured when start is accepted
//   busy            - high while bits are being evaluated
//   done            - one-cycle pulse, result valid
//   dataOut         - registered result, held until the next op completes
//   cOut, zero, overflow - result flags
module serial_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             cOut,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

  // Per-bit datapath signals derived from the captured operation
  logic             is_sub, is_logic;
  logic             a_bit, b_eff, sum_bit, carry_next, res_bit, ovf_bit;
  logic [WIDTH-1:0] res_full;

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // One bit of the serial adder / logic unit
  always_comb begin
    is_sub     = op_is_sub(op_q);
    is_logic   = (op_q == OP_AND) || (op_q == OP_OR);
    a_bit      = a_q[cnt_q];
    b_eff      = b_q[cnt_q] ^ is_sub;
    sum_bit    = a_bit ^ b_eff ^ carry_q;
    carry_next = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
    unique case (op_q)
      OP_AND:  res_bit = a_bit & b_q[cnt_q];
      OP_OR:   res_bit = a_bit | b_q[cnt_q];
      default: res_bit = sum_bit;
    endcase
    // On the last bit carry_q is the carry into the MSB
    ovf_bit  = is_logic ? 1'b0 : (carry_q ^ carry_next);
    res_full = {res_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and output-register logic
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    res_d      = res_q;
    data_out_d = data_out_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = dataA;
          b_d     = dataB;
          op_d    = signal;
          cnt_d   = '0;
          carry_d = op_is_sub(signal);
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = res_full;
        carry_d = is_logic ? 1'b0 : carry_next;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          if (op_q == OP_SLT) begin
            data_out_d = {{(WIDTH-1){1'b0}}, sum_bit ^ ovf_bit};
          end else begin
            data_out_d = res_full;
          end
          cout_d = is_logic ? 1'b0 : carry_next;
          ovf_d  = ovf_bit;
          zero_d = (data_out_d == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      res_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dataOut  = data_out_q;
  assign cOut     = cout_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq (WIDTH=32): vector table plus handshake/reset sequences.
module tb_serial_alu_seq;

  localparam int unsigned W = 32;
  localparam int LAT = 32;      // edges from accept to done
  localparam int BUDGET = 40;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [2:0]   signal;
  logic [W-1:0] dataA, dataB;
  logic         busy, done, cOut, zero, overflow;
  logic [W-1:0] dataOut;

  int total = 0;
  int bad = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signal(signal),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .dataOut(dataOut), .cOut(cOut), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present an op before the next edge; that edge accepts it
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signal = op; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done; returns latency, busy samples and busy/done overlap
  task automatic wait_done(output int cyc, output int busy_cnt, output int overlap);
    cyc = 0; busy_cnt = 0; overlap = 0;
    while (cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (busy && done) overlap++;
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input string name, input vec_t v);
    check({name, ".data"}, dataOut, v.res);
    check({name, ".cout"}, 32'(cOut), 32'(v.c));
    check({name, ".zero"}, 32'(zero), 32'(v.z));
    check({name, ".ovf"},  32'(overflow), 32'(v.v));
  endtask

  int cyc, bcnt, ovl, pulses;
  vec_t v;

  initial begin
    rst_n = 1'b0; start = 1'b0; signal = '0; dataA = '0; dataB = '0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.data", dataOut, 32'd0);
    check("rst.zero", 32'(zero), 32'd1);
    check("rst.cout", 32'(cOut), 32'd0);
    check("rst.ovf",  32'(overflow), 32'd0);
    rst_n = 1'b1;

    //                  name       op    a             b             res           c     z     v
    vecs.push_back('{"add_wrap",  3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"add_ovf",   3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"add_negov", 3'd2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"sub_neg",   3'd6, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub_eq",    3'd6, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"sub_ovf",   3'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"slt_ovf",   3'd7, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"slt_gt",    3'd7, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"slt_m1",    3'd7, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"and",       3'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"or",        3'd1, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"and_zero",  3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"ill4",      3'd4, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"ill5_cin",  3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"ill3",      3'd3, 32'h00000010, 32'hFFFFFFFF, 32'h0000000F, 1'b1, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      v = vecs[i];
      issue(v.op, v.a, v.b);
      check({v.name, ".busy_after_start"}, 32'(busy), 32'd1);
      wait_done(cyc, bcnt, ovl);
      check({v.name, ".latency"}, 32'(cyc), 32'(LAT));
      check({v.name, ".busy_cycles"}, 32'(bcnt), 32'(LAT - 1));
      check({v.name, ".overlap"}, 32'(ovl), 32'd0);
      check_result(v.name, v);
      @(posedge clk); #1;
      check({v.name, ".done_one_cycle"}, 32'(done), 32'd0);
      check({v.name, ".hold"}, dataOut, v.res);
    end

    // start pulsed at RUN bit 5 is ignored
    issue(3'd2, 32'd10, 32'd20);
    repeat (4) @(posedge clk);
    start = 1'b1; signal = 3'd6; dataA = 32'd100; dataB = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bcnt, ovl);
    check("ignore.latency", 32'(cyc + 5), 32'(LAT));
    check("ignore.data", dataOut, 32'd30);

    // start during the done cycle is accepted; next done 33 cycles later
    start = 1'b1; signal = 3'd6; dataA = 32'd100; dataB = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.done_low", 32'(done), 32'd0);
    check("b2b.first_held", dataOut, 32'd30);
    wait_done(cyc, bcnt, ovl);
    check("b2b.latency", 32'(cyc + 1), 32'(LAT + 1));
    check("b2b.data", dataOut, 32'd99);
    check("b2b.cout", 32'(cOut), 32'd1);

    // Reset in the middle of RUN (bit 10) discards the op
    issue(3'd6, 32'd5, 32'd7);
    wait_done(cyc, bcnt, ovl);
    check("pre_rst.data", dataOut, 32'hFFFFFFFE);
    issue(3'd2, 32'h12345678, 32'h11111111);
    repeat (9) @(posedge clk);
    #1;
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.data", dataOut, 32'd0);
    check("midrst.zero", 32'(zero), 32'd1);
    check("midrst.ovf",  32'(overflow), 32'd0);
    pulses = 0;
    repeat (BUDGET) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midrst.no_done", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
